fpnew_intdiv_iter: RTL

//  Iterative radix-2 integer divide/remainder unit. It sits in the FPU's multi-cycle op group

---
 rtl/fpnew_intdiv_iter_if.sv | 30 +++
 rtl/fpnew_intdiv_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fpnew_intdiv_iter_if.sv
// Handshake/data bundle for the iterative integer divider: operands, op, tag,
// valid/ready in both directions, flush and busy.
interface fpnew_intdiv_iter_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TagWidth = 4
);
    logic [WIDTH-1:0]    operand_a_i;
    logic [WIDTH-1:0]    operand_b_i;
    logic [1:0]          op_i;
    logic [TagWidth-1:0] tag_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                flush_i;
    logic [WIDTH-1:0]    result_o;
    logic                div_zero_o;
    logic [TagWidth-1:0] tag_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                busy_o;

    modport slave (
        input  operand_a_i, operand_b_i, op_i, tag_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, result_o, div_zero_o, tag_o, out_valid_o, busy_o
    );

    modport master (
        output operand_a_i, operand_b_i, op_i, tag_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, result_o, div_zero_o, tag_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/fpnew_intdiv_iter.sv
// Iterative radix-2 restoring integer DIV/REM unit (signed/unsigned, RISC-V corner cases).
// Optional macro FPNEW_INTDIV_EARLY_OUT_EN: skip iteration when b==0, a==0 or |a|<|b|.
module fpnew_intdiv_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TagWidth = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    fpnew_intdiv_iter_if.slave io
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                is_rem_q, is_rem_d;
    logic                dz_q, dz_d;
    logic [TagWidth-1:0] tag_q, tag_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                div_zero_q, div_zero_d;
    logic [TagWidth-1:0] tag_out_q, tag_out_d;

    logic kill, accept, in_ready, out_valid;
    logic is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift;
    logic             ge;
    logic [WIDTH-1:0] rem_sub, rem_step, quo_step, q_fix, r_fix;

    // Reset behaves like a flush for the handshake outputs.
    assign kill      = io.flush_i | rst_i;
    assign in_ready  = ~kill & ((state_q == IDLE) | ((state_q == DONE) & io.out_ready_i));
    assign out_valid = ~kill & (state_q == DONE);
    assign accept    = io.in_valid_i & in_ready;

    assign is_signed = io.op_i[0];
    assign a_neg     = is_signed & io.operand_a_i[WIDTH-1];
    assign b_neg     = is_signed & io.operand_b_i[WIDTH-1];
    assign a_mag     = a_neg ? -io.operand_a_i : io.operand_a_i;
    assign b_mag     = b_neg ? -io.operand_b_i : io.operand_b_i;
    assign b_zero    = (io.operand_b_i == '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign ge        = rem_shift >= {1'b0, dvs_q};
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    assign rem_step  = ge ? rem_sub : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], ge};

    // Divide-by-zero keeps an all-ones quotient; remainder sign follows the dividend.
    assign q_fix = dz_q ? '1 : (neg_quo_q ? -quo_step : quo_step);
    assign r_fix = neg_rem_q ? -rem_step : rem_step;

`ifdef FPNEW_INTDIV_EARLY_OUT_EN
    logic early;
    assign early = b_zero | (io.operand_a_i == '0) | (a_mag < b_mag);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            dz_q       <= 1'b0;
            tag_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            tag_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            dz_q       <= dz_d;
            tag_q      <= tag_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            tag_out_q  <= tag_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        dz_d       = dz_q;
        tag_d      = tag_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        tag_out_d  = tag_out_q;

        if (kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    quo_d = quo_step;
                    rem_d = rem_step;
                    if (cnt_q == '0) begin
                        state_d    = DONE;
                        result_d   = is_rem_q ? r_fix : q_fix;
                        div_zero_d = dz_q;
                        tag_out_d  = tag_q;
                    end
                end
                DONE: begin
                    if (io.out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Accept is only possible from IDLE or a completing DONE.
            if (accept) begin
                state_d   = BUSY;
                cnt_d     = CntW'(WIDTH - 1);
                quo_d     = a_mag;
                rem_d     = '0;
                dvs_d     = b_mag;
                neg_quo_d = is_signed & (io.operand_a_i[WIDTH-1] ^ io.operand_b_i[WIDTH-1]);
                neg_rem_d = a_neg;
                is_rem_d  = io.op_i[1];
                dz_d      = b_zero;
                tag_d     = io.tag_i;
`ifdef FPNEW_INTDIV_EARLY_OUT_EN
                if (early) begin
                    state_d    = DONE;
                    result_d   = io.op_i[1] ? io.operand_a_i : (b_zero ? '1 : '0);
                    div_zero_d = b_zero;
                    tag_out_d  = io.tag_i;
                end
`endif
            end
        end
    end

    assign io.in_ready_o  = in_ready;
    assign io.out_valid_o = out_valid;
    assign io.busy_o      = (state_q != IDLE) & ~kill;
    assign io.result_o    = result_q;
    assign io.div_zero_o  = div_zero_q;
    assign io.tag_o       = tag_out_q;
endmodule
